instr_fetch_unit: RTL and testbench
===================================

Name: instr_fetch_unit

Overview:
- Front end of the single-cycle core: owns the PC, fetches 32-bit MIPS-format words from instruction memory over a req/valid handshake, and holds each word in an instruction register.
- Drives the opcode, funct and operand fields that the control decoder consumes.
- Samples the decoder's jump/PCsrc outputs to select the next PC.
- Sequential: fetch FSM, PC register, instruction register, retire counter.

Parameters:
- PC_WIDTH, 32, width of PC and instruction-memory byte address.
- RESET_PC, 32'h0000_0000, PC loaded on reset.

Ports:
- clk  input  1  core clock, all state updates on rising edge.
- rst_n  input  1  synchronous active-low reset.
- imem_req  output  1  fetch request, held until imem_valid.
- imem_addr  output  PC_WIDTH  byte address of fetch (always the current PC).
- imem_rdata  input  32  instruction word, qualified by imem_valid.
- imem_valid  input  1  one-cycle response strobe for the outstanding request.
- opcode  output  7  {1'b0, IR[31:26]}.
- funct  output  6  IR[5:0].
- rs, rt, rd  output  5 each  IR[25:21], IR[20:16], IR[15:11].
- imm  output  32  sign-extended IR[15:0].
- instr_valid  output  1  fields are valid and the decoder outputs are being sampled this cycle.
- jump  input  1  from decoder: take jump.
- PCsrc  input  1  from decoder: branch taken (already gated with zero).
- stall  input  1  hold the current instruction; do not advance.
- pc  output  PC_WIDTH  address of the instruction in IR.
- retire_count  output  32  instructions retired since reset.

Behaviour:
- Reset (rst_n=0 at clk edge):
  - state=IDLE, PC=RESET_PC, IR=0, imem_req=0, instr_valid=0, retire_count=0.
  - All field outputs are derived from IR, so they read 0 (opcode=0, imm=0).
- States:
  - IDLE:
    - One cycle after reset release; no request.
    - Next state FETCH.
  - FETCH:
    - imem_req=1, imem_addr=PC.
    - On imem_valid=1: IR<=imem_rdata; next state ISSUE.
    - Otherwise stay, with request held and address stable.
  - ISSUE:
    - instr_valid=1; imem_req=0.
    - If stall=1: stay in ISSUE; PC, IR and count unchanged.
    - Else:
      - PC<=next_pc;
      - retire_count<=retire_count+1, wrapping 32'hFFFF_FFFF to 0;
      - next state FETCH.
- next_pc, with pc4=PC+4 modulo 2^PC_WIDTH:
  - jump=1: {pc4[PC_WIDTH-1:28], IR[25:0], 2'b00}. jump takes priority over PCsrc if both are asserted.
  - else PCsrc=1: pc4 + (imm<<2), truncated to PC_WIDTH; a negative offset wraps.
  - else: pc4.
- Latency: a zero-wait memory gives 1 FETCH cycle + 1 ISSUE cycle per instruction. Each memory wait cycle adds one FETCH cycle.
- Ignored inputs:
  - imem_valid outside FETCH is ignored and does not modify IR.
  - jump, PCsrc and stall are ignored outside ISSUE.
- Reset mid-FETCH:
  - imem_req drops on the reset edge.
  - A late imem_valid arriving while in IDLE is ignored; the fetch restarts at RESET_PC.
- Reset with imem_valid in the same cycle: reset wins and IR=0.
- Pipelining: no outstanding-request queue; at most one request is in flight.

Test Plan:
- Reset/sequential:
  - Stimulus: assert rst_n=0 for 2 cycles, then release; memory returns add (opcode 0, funct 6'h20) at 0x0, 0x4, 0x8 with zero wait.
  - Required: imem_addr sequence 0x0, 0x4, 0x8; instr_valid pulses every 2nd cycle; retire_count=3.
- Branch taken:
  - Stimulus: beq at PC=0x10 with IR[15:0]=16'hFFFE; PCsrc=1 during ISSUE.
  - Required: next imem_addr=0x0C, opcode=7'd4.
- Jump priority:
  - Stimulus: j at PC=0x2000_0004 with target 26'h0000040; jump=1 and PCsrc=1 simultaneously.
  - Required: next PC=0x2000_0100.
- Wait states and stall:
  - Stimulus: imem_valid delayed 3 cycles; then stall=1 held for 4 ISSUE cycles.
  - Required: imem_req and addr are stable for 4 cycles; instr_valid stays high 5 cycles; PC and retire_count are frozen until stall drops.
- Reset mid-fetch:
  - Stimulus: pull rst_n low while in FETCH at PC=0x40; drive imem_valid=1 with 0xDEADBEEF in the following IDLE cycle.
  - Required: IR stays 0, and the next request goes to RESET_PC.
- Wrap:
  - Stimulus: PC=0xFFFF_FFFC, sequential instruction.
  - Required: next PC=0x0000_0000.
  - Stimulus: preload retire_count to 0xFFFF_FFFF via a bench force, retire one instruction.
  - Required: retire_count=0.

Source files
------------

// File: rtl/instr_fetch_unit_if.sv
// rtl/instr_fetch_unit_if.sv - instruction-memory request/response handshake
interface instr_fetch_unit_if #(
    parameter int PC_WIDTH = 32
);
    logic                req;
    logic [PC_WIDTH-1:0] addr;
    logic [31:0]         rdata;
    logic                valid;

    modport master (output req, output addr, input rdata, input valid);
    modport slave  (input req, input addr, output rdata, output valid);
endinterface

// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - PC, fetch FSM, instruction register and retire counter
module instr_fetch_unit #(
    parameter int                  PC_WIDTH = 32,
    parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
    input  logic                clk,
    input  logic                rst_n,
    instr_fetch_unit_if.master  imem,
    output logic [6:0]          opcode,
    output logic [5:0]          funct,
    output logic [4:0]          rs,
    output logic [4:0]          rt,
    output logic [4:0]          rd,
    output logic [31:0]         imm,
    output logic                instr_valid,
    input  logic                jump,
    input  logic                PCsrc,
    input  logic                stall,
    output logic [PC_WIDTH-1:0] pc,
    output logic [31:0]         retire_count
);

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        ISSUE
    } state_t;

    state_t              state_q, state_d;
    logic [PC_WIDTH-1:0] pc_q, pc_d, pc4, next_pc;
    logic [31:0]         ir_q, ir_d;
    logic [31:0]         retire_q, retire_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            pc_q     <= RESET_PC;
            ir_q     <= '0;
            retire_q <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            ir_q     <= ir_d;
            retire_q <= retire_d;
        end
    end

    assign opcode       = {1'b0, ir_q[31:26]};
    assign funct        = ir_q[5:0];
    assign rs           = ir_q[25:21];
    assign rt           = ir_q[20:16];
    assign rd           = ir_q[15:11];
    assign imm          = {{16{ir_q[15]}}, ir_q[15:0]};
    assign pc           = pc_q;
    assign retire_count = retire_q;
    assign imem.addr    = pc_q;

    // Jump wins over a taken branch when the decoder raises both.
    always_comb begin
        pc4 = pc_q + PC_WIDTH'(4);
        if (jump) begin
            next_pc = {pc4[PC_WIDTH-1:28], ir_q[25:0], 2'b00};
        end else if (PCsrc) begin
            next_pc = pc4 + PC_WIDTH'(imm << 2);
        end else begin
            next_pc = pc4;
        end
    end

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        ir_d        = ir_q;
        retire_d    = retire_q;
        imem.req    = 1'b0;
        instr_valid = 1'b0;
        case (state_q)
            IDLE: begin
                state_d = FETCH;
            end
            FETCH: begin
                imem.req = 1'b1;
                if (imem.valid) begin
                    ir_d    = imem.rdata;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                instr_valid = 1'b1;
                if (!stall) begin
                    pc_d     = next_pc;
                    retire_d = retire_q + 32'd1;
                    state_d  = FETCH;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb/tb_instr_fetch_unit.sv - directed vector bench for instr_fetch_unit
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [6:0]  opcode;
    logic [5:0]  funct;
    logic [4:0]  rs, rt, rd;
    logic [31:0] imm;
    logic        instr_valid;
    logic        jump, PCsrc, stall;
    logic [31:0] pc;
    logic [31:0] retire_count;

    instr_fetch_unit_if #(.PC_WIDTH(32)) imem ();

    instr_fetch_unit #(.PC_WIDTH(32), .RESET_PC(32'h0000_0000)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .imem         (imem.master),
        .opcode       (opcode),
        .funct        (funct),
        .rs           (rs),
        .rt           (rt),
        .rd           (rd),
        .imm          (imm),
        .instr_valid  (instr_valid),
        .jump         (jump),
        .PCsrc        (PCsrc),
        .stall        (stall),
        .pc           (pc),
        .retire_count (retire_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] instr;
        logic        j;
        logic        ps;
        logic [31:0] addr;
        logic [6:0]  op;
        logic [5:0]  fn;
        logic [31:0] simm;
    } vec_t;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_retire = 32'd0;
    vec_t        vecs[9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Enter at a negedge in (or just before) FETCH; leave at the first ISSUE negedge.
    task automatic fetch_to_issue(input logic [31:0] word, input int waits, input logic [31:0] exp_addr);
        int n = 0;
        while (!imem.req && n < 8) begin
            @(negedge clk);
            n++;
        end
        chk("fetch_req", {31'd0, imem.req}, 32'd1);
        chk("fetch_addr", imem.addr, exp_addr);
        chk("fetch_instr_valid", {31'd0, instr_valid}, 32'd0);
        for (int w = 0; w < waits; w++) begin
            @(negedge clk);
            chk("wait_req", {31'd0, imem.req}, 32'd1);
            chk("wait_addr", imem.addr, exp_addr);
        end
        imem.valid = 1'b1;
        imem.rdata = word;
        @(negedge clk);
        imem.valid = 1'b0;
        imem.rdata = $urandom;
        chk("issue_instr_valid", {31'd0, instr_valid}, 32'd1);
        chk("issue_req", {31'd0, imem.req}, 32'd0);
        chk("issue_pc", pc, exp_addr);
    endtask

    task automatic issue(input logic j, input logic ps, input int stalls, input logic [31:0] exp_pc);
        jump  = j;
        PCsrc = ps;
        stall = (stalls > 0);
        for (int s = 0; s < stalls; s++) begin
            @(negedge clk);
            chk("stall_instr_valid", {31'd0, instr_valid}, 32'd1);
            chk("stall_pc", pc, exp_pc);
            chk("stall_retire", retire_count, exp_retire);
        end
        stall = 1'b0;
        @(negedge clk);
        jump  = 1'b0;
        PCsrc = 1'b0;
        exp_retire = exp_retire + 32'd1;
        chk("retire_count", retire_count, exp_retire);
        chk("post_issue_instr_valid", {31'd0, instr_valid}, 32'd0);
    endtask

    initial begin
        vecs[0] = '{32'h0022_1820, 1'b0, 1'b0, 32'h0000_0000, 7'd0, 6'h20, 32'h0000_1820};
        vecs[1] = '{32'h0022_1820, 1'b0, 1'b0, 32'h0000_0004, 7'd0, 6'h20, 32'h0000_1820};
        vecs[2] = '{32'h0022_1820, 1'b0, 1'b0, 32'h0000_0008, 7'd0, 6'h20, 32'h0000_1820};
        vecs[3] = '{32'h0022_1820, 1'b0, 1'b0, 32'h0000_000C, 7'd0, 6'h20, 32'h0000_1820};
        vecs[4] = '{32'h1022_FFFE, 1'b0, 1'b1, 32'h0000_0010, 7'd4, 6'h3E, 32'hFFFF_FFFE};
        vecs[5] = '{32'h1064_FFFC, 1'b0, 1'b1, 32'h0000_000C, 7'd4, 6'h3C, 32'hFFFF_FFFC};
        vecs[6] = '{32'h1022_FFFE, 1'b0, 1'b1, 32'h0000_0000, 7'd4, 6'h3E, 32'hFFFF_FFFE};
        vecs[7] = '{32'h0022_1820, 1'b0, 1'b0, 32'hFFFF_FFFC, 7'd0, 6'h20, 32'h0000_1820};
        vecs[8] = '{32'h1022_000F, 1'b0, 1'b1, 32'h0000_0000, 7'd4, 6'h0F, 32'h0000_000F};

        rst_n      = 1'b0;
        jump       = 1'b0;
        PCsrc      = 1'b0;
        stall      = 1'b0;
        imem.valid = 1'b0;
        imem.rdata = 32'd0;
        repeat (2) @(negedge clk);
        chk("rst_req", {31'd0, imem.req}, 32'd0);
        chk("rst_instr_valid", {31'd0, instr_valid}, 32'd0);
        chk("rst_opcode", {25'd0, opcode}, 32'd0);
        chk("rst_imm", imm, 32'd0);
        chk("rst_pc", pc, 32'd0);
        chk("rst_retire", retire_count, 32'd0);
        rst_n = 1'b1;
        chk("idle_req", {31'd0, imem.req}, 32'd0);

        for (int i = 0; i < 9; i++) begin
            fetch_to_issue(vecs[i].instr, 0, vecs[i].addr);
            chk("opcode", {25'd0, opcode}, {25'd0, vecs[i].op});
            chk("funct", {26'd0, funct}, {26'd0, vecs[i].fn});
            chk("imm", imm, vecs[i].simm);
            chk("rs", {27'd0, rs}, {27'd0, vecs[i].instr[25:21]});
            chk("rt", {27'd0, rt}, {27'd0, vecs[i].instr[20:16]});
            chk("rd", {27'd0, rd}, {27'd0, vecs[i].instr[15:11]});
            issue(vecs[i].j, vecs[i].ps, 0, vecs[i].addr);
        end

        // Reset lands mid-fetch with a response in the same cycle, then a late response in IDLE.
        chk("midfetch_req", {31'd0, imem.req}, 32'd1);
        chk("midfetch_addr", imem.addr, 32'h0000_0040);
        rst_n      = 1'b0;
        imem.valid = 1'b1;
        imem.rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        chk("midrst_req", {31'd0, imem.req}, 32'd0);
        chk("midrst_opcode", {25'd0, opcode}, 32'd0);
        chk("midrst_imm", imm, 32'd0);
        chk("midrst_pc", pc, 32'd0);
        chk("midrst_retire", retire_count, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        imem.valid = 1'b0;
        exp_retire = 32'd0;
        chk("late_valid_opcode", {25'd0, opcode}, 32'd0);
        chk("late_valid_imm", imm, 32'd0);
        chk("restart_req", {31'd0, imem.req}, 32'd1);
        chk("restart_addr", imem.addr, 32'h0000_0000);

        // Jump and branch together: jump target must win.
        force dut.pc_q = 32'h2000_0004;
        #1 release dut.pc_q;
        fetch_to_issue(32'h0800_0040, 0, 32'h2000_0004);
        chk("j_opcode", {25'd0, opcode}, 32'd2);
        issue(1'b1, 1'b1, 0, 32'h2000_0004);

        // Three memory wait cycles, then four stalled ISSUE cycles.
        fetch_to_issue(32'h0022_1820, 3, 32'h2000_0100);
        issue(1'b0, 1'b0, 4, 32'h2000_0100);
        chk("after_stall_addr", imem.addr, 32'h2000_0104);

        force dut.retire_q = 32'hFFFF_FFFF;
        #1 release dut.retire_q;
        exp_retire = 32'hFFFF_FFFF;
        fetch_to_issue(32'h0022_1820, 0, 32'h2000_0104);
        chk("retire_preload", retire_count, 32'hFFFF_FFFF);
        issue(1'b0, 1'b0, 0, 32'h2000_0104);
        chk("retire_wrap", retire_count, 32'h0000_0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout actual=running expected=finished");
        $fatal(1);
    end

endmodule
